// File: rtl/memory_data_port.sv
// Memory address/data register pair with a req/ack handshake to external memory.
// Optional wait-state timeout abort is built when MEM_TIMEOUT_EN is defined.
module memory_data_port #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       BusMuxIn_MDR,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
`else
  logic [7:0] timeout_unused_s;
  assign timeout_unused_s = 8'(TIMEOUT);
`endif

  // Next-state and next-output computation for the handshake FSM.
  always_comb begin
    state_d  = state_q;
    mar_d    = mar_q;
    mdr_d    = mdr_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
        if (MARin) begin
          mar_d = BusMuxOut[ADDR_W-1:0];
        end else begin
          mar_d = mar_q;
        end
        // Read takes priority over a concurrent MDR load.
        if (MDRin && !Read) begin
          mdr_d = BusMuxOut;
        end else begin
          mdr_d = mdr_q;
        end
        if (Read && Write) begin
          err_d = 1'b1;
        end else if (Read) begin
          state_d  = RD_WAIT;
          mem_rd_d = 1'b1;
          busy_d   = 1'b1;
          err_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d    = 8'd0;
`endif
        end else if (Write) begin
          state_d  = WR_WAIT;
          mem_wr_d = 1'b1;
          busy_d   = 1'b1;
          err_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d    = 8'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack) begin
          if (state_q == RD_WAIT) begin
            mdr_d = mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
          state_d  = DONE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
`ifdef MEM_TIMEOUT_EN
          // The edge that would bring the counter to TIMEOUT aborts instead.
          if (cnt_q == TMO_LAST) begin
            state_d  = IDLE;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            busy_d   = 1'b0;
            err_d    = 1'b1;
            cnt_d    = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`else
          state_d = state_q;
`endif
        end
      end
      default: begin
        state_d  = IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops with asynchronous active-low clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= IDLE;
      mar_q    <= '0;
      mdr_q    <= 32'd0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      mar_q    <= mar_d;
      mdr_q    <= mdr_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign mem_addr     = mar_q;
  assign mem_wdata    = mdr_q;
  assign BusMuxIn_MDR = mdr_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_memory_data_port.sv
// Self-checking bench for memory_data_port: randomized transactions against a
// register-level model of MAR, MDR and the error flag.
module tb_memory_data_port;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;

  logic              clock;
  logic              clear;
  logic [31:0]       BusMuxOut;
  logic              MARin, MDRin, Read, Write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rd, mem_wr;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic [31:0]       BusMuxIn_MDR;
  logic              busy, done, err;

  int errors = 0;
  int checks = 0;

  // Model of the architectural state, updated from the behavioural rules.
  logic [ADDR_W-1:0] m_mar;
  logic [31:0]       m_mdr;
  logic              m_err;

  memory_data_port #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MARin(MARin),
    .MDRin(MDRin), .Read(Read), .Write(Write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .BusMuxIn_MDR(BusMuxIn_MDR),
    .busy(busy), .done(done), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic model_reset();
    m_mar = '0; m_mdr = 32'd0; m_err = 1'b0;
  endtask

  task automatic load_regs(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    MARin = 1'b1; BusMuxOut = 32'(a); tick(); MARin = 1'b0; m_mar = a;
    MDRin = 1'b1; BusMuxOut = d;      tick(); MDRin = 1'b0; m_mdr = d;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      BusMuxOut = $urandom; mem_rdata = $urandom;
      MARin = 1'($urandom); MDRin = 1'($urandom); Read = 1'($urandom);
      Write = 1'($urandom); mem_ack = 1'($urandom);
      tick();
      checks++;
      if ({mem_addr, mem_wdata, BusMuxIn_MDR, mem_rd, mem_wr, busy, done, err} !== '0) begin
        errors++;
        $display("FAIL reset_hold: addr=%h wdata=%h mdr=%h rd=%b wr=%b busy=%b done=%b err=%b, required all 0",
                 mem_addr, mem_wdata, BusMuxIn_MDR, mem_rd, mem_wr, busy, done, err);
      end
    end
    idle_inputs();
    clear = 1'b1;
    model_reset();
    tick();
    checks++;
    if ({mem_addr, mem_wdata, BusMuxIn_MDR, mem_rd, mem_wr, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_release: addr=%h wdata=%h rd=%b wr=%b busy=%b done=%b err=%b, required all 0",
               mem_addr, mem_wdata, mem_rd, mem_wr, busy, done, err);
    end
  endtask

  task automatic run_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input int lat);
    int wr_cycles = 0;
    int done_cnt  = 0;
    load_regs(a, d);
    Write = 1'b1; tick(); Write = 1'b0; m_err = 1'b0;
    checks++;
    if (mem_addr !== m_mar || mem_wdata !== m_mdr || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_issue: addr=%h wdata=%h busy=%b, required addr=%h wdata=%h busy=1",
               mem_addr, mem_wdata, busy, m_mar, m_mdr);
    end
    if (mem_wr === 1'b1) wr_cycles++;
    for (int k = 1; k < lat; k++) begin
      BusMuxOut = $urandom;
      tick();
      if (mem_wr === 1'b1) wr_cycles++;
      if (done === 1'b1) done_cnt++;
      checks++;
      if (mem_wdata !== m_mdr || mem_addr !== m_mar) begin
        errors++;
        $display("FAIL write_hold: addr=%h wdata=%h, required addr=%h wdata=%h",
                 mem_addr, mem_wdata, m_mar, m_mdr);
      end
    end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    if (mem_wr === 1'b1) wr_cycles++;
    if (done === 1'b1) done_cnt++;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL write_ack: busy=%b err=%b, required busy=0 err=0", busy, err);
    end
    tick();
    if (done === 1'b1) done_cnt++;
    checks++;
    if (wr_cycles != lat || done_cnt != 1) begin
      errors++;
      $display("FAIL write_pulses: wr_cycles=%0d done_pulses=%0d, required %0d and 1",
               wr_cycles, done_cnt, lat);
    end
  endtask

  task automatic run_read(input logic [ADDR_W-1:0] a, input logic [31:0] rd, input int lat,
                          input logic junk_mdr);
    MARin = 1'b1; BusMuxOut = 32'(a); tick(); MARin = 1'b0; m_mar = a;
    Read = 1'b1; MDRin = junk_mdr; BusMuxOut = 32'h0000_0005;
    tick(); Read = 1'b0; MDRin = 1'b0; m_err = 1'b0;
    checks++;
    if (mem_rd !== 1'b1 || busy !== 1'b1 || mem_addr !== m_mar || BusMuxIn_MDR !== m_mdr) begin
      errors++;
      $display("FAIL read_issue: rd=%b busy=%b addr=%h mdr=%h, required rd=1 busy=1 addr=%h mdr=%h",
               mem_rd, busy, mem_addr, BusMuxIn_MDR, m_mar, m_mdr);
    end
    for (int k = 1; k < lat; k++) begin
      mem_rdata = $urandom;
      tick();
      checks++;
      if (mem_rd !== 1'b1 || done !== 1'b0 || BusMuxIn_MDR !== m_mdr) begin
        errors++;
        $display("FAIL read_wait: rd=%b done=%b mdr=%h, required rd=1 done=0 mdr=%h",
                 mem_rd, done, BusMuxIn_MDR, m_mdr);
      end
    end
    mem_ack = 1'b1; mem_rdata = rd; tick(); mem_ack = 1'b0; mem_rdata = $urandom;
    m_mdr = rd;
    checks++;
    if (done !== 1'b1 || mem_rd !== 1'b0 || busy !== 1'b0 || BusMuxIn_MDR !== m_mdr) begin
      errors++;
      $display("FAIL read_ack: done=%b rd=%b busy=%b mdr=%h, required done=1 rd=0 busy=0 mdr=%h",
               done, mem_rd, busy, BusMuxIn_MDR, m_mdr);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0 || err !== m_err) begin
      errors++;
      $display("FAIL read_idle: done=%b busy=%b rd=%b err=%b, required 0 0 0 %b",
               done, busy, mem_rd, err, m_err);
    end
  endtask

  task automatic test_write();
    run_write(9'h01F, 32'hDEAD_BEEF, 3);
  endtask

  task automatic test_read();
    run_read(9'h01F, 32'hCAFE_F00D, 1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_write(ADDR_W'($urandom), $urandom, int'($urandom_range(1, 10)));
      run_read(ADDR_W'($urandom), $urandom, int'($urandom_range(1, 10)), 1'($urandom));
    end
  endtask

  task automatic test_busy_lockout();
    MARin = 1'b1; BusMuxOut = 32'h0000_001F; tick(); MARin = 1'b0; m_mar = 9'h01F;
    Read = 1'b1; tick(); Read = 1'b0;
    MARin = 1'b1; MDRin = 1'b1; Write = 1'b1; BusMuxOut = 32'h0000_0003;
    tick(); tick();
    idle_inputs();
    checks++;
    if (mem_addr !== 9'h01F || mem_wr !== 1'b0 || mem_rd !== 1'b1 || BusMuxIn_MDR !== m_mdr) begin
      errors++;
      $display("FAIL lockout_hold: addr=%h wr=%b rd=%b mdr=%h, required addr=01f wr=0 rd=1 mdr=%h",
               mem_addr, mem_wr, mem_rd, BusMuxIn_MDR, m_mdr);
    end
    mem_ack = 1'b1; mem_rdata = $urandom; m_mdr = mem_rdata; tick(); mem_ack = 1'b0;
    tick(); tick();
    checks++;
    if (mem_wr !== 1'b0 || busy !== 1'b0 || mem_addr !== 9'h01F || BusMuxIn_MDR !== m_mdr) begin
      errors++;
      $display("FAIL lockout_after: wr=%b busy=%b addr=%h mdr=%h, required wr=0 busy=0 addr=01f mdr=%h",
               mem_wr, busy, mem_addr, BusMuxIn_MDR, m_mdr);
    end
  endtask

  task automatic test_timeout();
    int done_cnt = 0;
    Read = 1'b1; tick(); Read = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int k = 1; k < TIMEOUT; k++) begin
      mem_rdata = $urandom; tick();
      if (done === 1'b1) done_cnt++;
      checks++;
      if (mem_rd !== 1'b1 || err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait: edge=%0d rd=%b err=%b, required rd=1 err=0", k, mem_rd, err);
      end
    end
    tick();
    if (done === 1'b1) done_cnt++;
    m_err = 1'b1;
    checks++;
    if (mem_rd !== 1'b0 || err !== 1'b1 || busy !== 1'b0 || BusMuxIn_MDR !== m_mdr) begin
      errors++;
      $display("FAIL timeout_abort: rd=%b err=%b busy=%b mdr=%h, required rd=0 err=1 busy=0 mdr=%h",
               mem_rd, err, busy, BusMuxIn_MDR, m_mdr);
    end
    tick(); tick();
    if (done === 1'b1) done_cnt++;
    checks++;
    if (done_cnt != 0 || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_nodone: done_pulses=%0d err=%b, required 0 and 1", done_cnt, err);
    end
    Write = 1'b1; tick(); Write = 1'b0; m_err = 1'b0;
    checks++;
    if (err !== 1'b0 || mem_wr !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: err=%b wr=%b, required err=0 wr=1", err, mem_wr);
    end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
`else
    for (int k = 1; k < TIMEOUT + 6; k++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    checks++;
    if (mem_rd !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL wait_persist: rd=%b busy=%b err=%b done_pulses=%0d, required 1 1 0 0",
               mem_rd, busy, err, done_cnt);
    end
    mem_ack = 1'b1; mem_rdata = $urandom; m_mdr = mem_rdata; tick(); mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || BusMuxIn_MDR !== m_mdr) begin
      errors++;
      $display("FAIL wait_ack: done=%b mdr=%h, required done=1 mdr=%h", done, BusMuxIn_MDR, m_mdr);
    end
    tick();
`endif
  endtask

  task automatic test_collision();
    MARin = 1'b1; MDRin = 1'b1; Read = 1'b1; Write = 1'b1; BusMuxOut = 32'h0000_0044;
    tick(); idle_inputs();
    m_mar = 9'h044; m_err = 1'b1;
    checks++;
    if (err !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || busy !== 1'b0 ||
        mem_addr !== m_mar || BusMuxIn_MDR !== m_mdr) begin
      errors++;
      $display("FAIL collision: err=%b rd=%b wr=%b busy=%b addr=%h mdr=%h, required 1 0 0 0 %h %h",
               err, mem_rd, mem_wr, busy, mem_addr, BusMuxIn_MDR, m_mar, m_mdr);
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    Write = 1'b1; tick(); Write = 1'b0;
    checks++;
    if (mem_wr !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_start: wr=%b err=%b, required wr=1 err=0", mem_wr, err);
    end
    #2 clear = 1'b0;
    #1;
    model_reset();
    checks++;
    if (mem_wr !== 1'b0 || busy !== 1'b0 || mem_wdata !== 32'd0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: wr=%b busy=%b wdata=%h addr=%h, required all 0",
               mem_wr, busy, mem_wdata, mem_addr);
    end
    tick();
    clear = 1'b1;
    mem_ack = 1'b1;
    tick();
    if (done === 1'b1) done_cnt++;
    mem_ack = 1'b0;
    tick();
    if (done === 1'b1) done_cnt++;
    checks++;
    if (done_cnt != 0 || mem_wr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nodone: done_pulses=%0d wr=%b busy=%b, required 0 0 0",
               done_cnt, mem_wr, busy);
    end
  endtask

  task automatic test_back_to_back();
    MARin = 1'b1; BusMuxOut = 32'h0000_0123; tick(); MARin = 1'b0; m_mar = 9'h123;
    Read = 1'b1; tick(); Read = 1'b0; m_err = 1'b0;
    mem_ack = 1'b1; mem_rdata = $urandom; m_mdr = mem_rdata; tick(); mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || BusMuxIn_MDR !== m_mdr) begin
      errors++;
      $display("FAIL b2b_done: done=%b mdr=%h, required done=1 mdr=%h", done, BusMuxIn_MDR, m_mdr);
    end
    Write = 1'b1; tick(); Write = 1'b0;
    checks++;
    if (mem_wr !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || mem_wdata !== m_mdr) begin
      errors++;
      $display("FAIL b2b_issue: wr=%b busy=%b done=%b wdata=%h, required 1 1 0 %h",
               mem_wr, busy, done, mem_wdata, m_mdr);
    end
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack: done=%b wr=%b, required done=1 wr=0", done, mem_wr);
    end
    tick();
  endtask

  initial begin
    clear = 1'b0;
    BusMuxOut = 32'd0; mem_rdata = 32'd0;
    idle_inputs();
    model_reset();
    test_reset();
    test_write();
    test_read();
    test_random();
    test_busy_lockout();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
